npc_predict: RTL
================

// Module: npc_predict
// PURPOSE
//  Parametrised next-PC unit for the pipelined CPU. Owns the PC register and a
//  direct-mapped BTB with 2-bit counters that predicts the IF next-PC. Resolves
//  branch/jump/jalr in EX and redirects with a flush on mispredict.
//  Sits between the IF stage (pc out) and EX (resolution inputs).
// PARAMETERS
//  WIDTH        32      address/data width
//  BTB_ENTRIES  16      BTB depth, power of 2, >=2; IDX=log2(BTB_ENTRIES)
//  RESET_PC     32'h0   PC value loaded on reset
// PORTS
//  clk            in   1      clock, rising edge
//  rstn           in   1      async active-low reset
//  pc_write       in   1      1=advance PC, 0=hold (hazard stall)
//  pc             out  WIDTH  current fetch PC (register)
//  pred_npc       out  WIDTH  predicted next PC for pc; pipelined to EX by core
//  ex_valid       in   1      EX holds a real instruction (0 for bubble)
//  ex_npcop       in   3      NPC_PLUS4 000, NPC_BRANCH 001, NPC_JUMP 010, NPC_JALR 100
//  ex_pc          in   WIDTH  PC of the EX instruction
//  ex_imm         in   WIDTH  immediate of the EX instruction
//  ex_aluout      in   WIDTH  jalr target from ALU
//  ex_taken       in   1      branch condition outcome (NPC_BRANCH only)
//  ex_pred_npc    in   WIDTH  pred_npc carried with the EX instruction
//  flush          out  1      combinational: kill IF/ID contents this cycle
// BEHAVIOUR
//  Actual next PC (EX, combinational):
//   PLUS4: ex_pc+4; BRANCH: ex_taken ? ex_pc+ex_imm : ex_pc+4;
//   JUMP: ex_pc+ex_imm; JALR: {ex_aluout[W-1:1],1'b0}; other codes: ex_pc+4.
//   All adds modulo 2^WIDTH (wrap, no carry out).
//  flush = ex_valid && (actual != ex_pred_npc).
//  Prediction (IF, combinational): idx=pc[IDX+1:2], tag=pc[W-1:IDX+2];
//   hit = valid[idx] && tag match; pred_npc = (hit && ctr[idx][1]) ? tgt[idx] : pc+4.
//  PC register at posedge, priority: flush -> actual; else pc_write -> pred_npc;
//   else hold. Redirect overrides stall.
//  BTB update at posedge when ex_valid and ex_npcop in {BRANCH,JUMP,JALR}:
//   index/tag from ex_pc; tgt <= taken target (ex_pc+ex_imm or jalr target).
//   Tag hit: ctr saturating +1 if taken, -1 if not (00..11), tgt rewritten only
//   if taken. Miss: allocate, valid=1, ctr = taken ? 10 : 01 (JUMP/JALR -> 11).
//   JUMP/JALR count as taken. Not-taken BRANCH misses do allocate.
//  Same-cycle read/write to same index: IF read sees pre-update contents.
//  Reset (async, rstn=0): pc=RESET_PC, all valid=0, ctr=01, tgt=0; perf counters 0.
//   Reset mid-redirect discards the redirect; first fetch after release is RESET_PC.
//  Latency: redirect visible on pc one cycle after flush; update used by the next
//   fetch that reads the entry on a later cycle.
// CONFIGURATION
//  NPC_PERF_EN defined: adds ports perf_ctl out WIDTH (count of ex_valid
//   BRANCH/JUMP/JALR) and perf_miss out WIDTH (count of flush cycles);
//   both increment at posedge, wrap at 2^WIDTH, clear on reset.
//  Not defined: ports and counters absent; all other behaviour identical.
// TESTING
//  1 Reset, pc_write=1, no EX ctl -> pc 0,4,8,0xC; flush=0 throughout.
//  2 pc_write=0 two cycles at pc=0x8 -> pc holds 0x8, then 0xC.
//  3 BRANCH ex_pc=0x10 imm=0x20 taken, ex_pred_npc=0x14 -> flush=1, next pc=0x30;
//    later fetch of 0x10 gives pred_npc=0x30 (ctr=10).
//  4 JALR ex_aluout=0x101, ex_pred_npc=0x104 -> flush=1, next pc=0x100;
//    pc_write=0 same cycle -> still 0x100 (redirect beats stall).
//  5 Entry for 0x10 valid; fetch 0x10+4*BTB_ENTRIES (same idx, tag differs)
//    -> pred_npc=pc+4; branch at 0x10 not taken twice from ctr=11 -> 01, predicts pc+4.
//  6 NPC_PERF_EN: tests 3+4 back-to-back -> perf_ctl=2, perf_miss=2; rstn low -> both 0.

Source files
------------

// File: rtl/npc_predict_if.sv
// Bundle of the IF-side fetch signals and EX-side resolution signals of the next-PC unit.
// slave: the npc_predict side; master: the pipeline/core side.
interface npc_predict_if #(
    parameter int unsigned WIDTH = 32
);
    logic             pc_write;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] pred_npc;
    logic             ex_valid;
    logic [2:0]       ex_npcop;
    logic [WIDTH-1:0] ex_pc;
    logic [WIDTH-1:0] ex_imm;
    logic [WIDTH-1:0] ex_aluout;
    logic             ex_taken;
    logic [WIDTH-1:0] ex_pred_npc;
    logic             flush;

    modport slave (
        input  pc_write, ex_valid, ex_npcop, ex_pc, ex_imm, ex_aluout, ex_taken, ex_pred_npc,
        output pc, pred_npc, flush
    );

    modport master (
        output pc_write, ex_valid, ex_npcop, ex_pc, ex_imm, ex_aluout, ex_taken, ex_pred_npc,
        input  pc, pred_npc, flush
    );
endinterface

// File: rtl/npc_predict.sv
// Next-PC unit: PC register plus a direct-mapped BTB with 2-bit counters predicting the
// IF next-PC; branches/jumps resolve in EX and redirect with a flush on mispredict.
// Optional build macro NPC_PERF_EN adds perf_ctl/perf_miss counter ports.
module npc_predict #(
    parameter int unsigned      WIDTH       = 32,
    parameter int unsigned      BTB_ENTRIES = 16,
    parameter logic [WIDTH-1:0] RESET_PC    = '0
) (
    input  logic             clk,
    input  logic             rstn,
    npc_predict_if.slave     bus
`ifdef NPC_PERF_EN
    ,
    output logic [WIDTH-1:0] perf_ctl,
    output logic [WIDTH-1:0] perf_miss
`endif
);
    localparam int unsigned IDX   = $clog2(BTB_ENTRIES);
    localparam int unsigned TAG_W = WIDTH - IDX - 2;

    localparam logic [2:0] NPC_PLUS4  = 3'b000;
    localparam logic [2:0] NPC_BRANCH = 3'b001;
    localparam logic [2:0] NPC_JUMP   = 3'b010;
    localparam logic [2:0] NPC_JALR   = 3'b100;

    logic [WIDTH-1:0] pc_q;
    logic [BTB_ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0] tag_q [BTB_ENTRIES];
    logic [WIDTH-1:0] tgt_q [BTB_ENTRIES];
    logic [1:0]       ctr_q [BTB_ENTRIES];

    logic [IDX-1:0]   if_idx, ex_idx;
    logic [TAG_W-1:0] if_tag, ex_tag;
    logic             if_hit, upd_hit, upd_en;
    logic             is_branch, is_jump, is_jalr, upd_taken;
    logic [WIDTH-1:0] ex_plus4, ex_rel, jalr_tgt, taken_tgt, actual_npc;

    assign if_idx = pc_q[IDX+1:2];
    assign if_tag = pc_q[WIDTH-1:IDX+2];
    assign ex_idx = bus.ex_pc[IDX+1:2];
    assign ex_tag = bus.ex_pc[WIDTH-1:IDX+2];

    // EX resolution: actual next PC, taken target and mispredict flush
    always_comb begin
        is_branch  = (bus.ex_npcop == NPC_BRANCH);
        is_jump    = (bus.ex_npcop == NPC_JUMP);
        is_jalr    = (bus.ex_npcop == NPC_JALR);
        ex_plus4   = bus.ex_pc + WIDTH'(4);
        ex_rel     = bus.ex_pc + bus.ex_imm;
        jalr_tgt   = {bus.ex_aluout[WIDTH-1:1], 1'b0};
        taken_tgt  = is_jalr ? jalr_tgt : ex_rel;
        upd_taken  = is_branch ? bus.ex_taken : 1'b1;
        upd_en     = bus.ex_valid && (is_branch || is_jump || is_jalr);
        upd_hit    = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
        actual_npc = ex_plus4;
        case (bus.ex_npcop)
            NPC_PLUS4:  actual_npc = ex_plus4;
            NPC_BRANCH: actual_npc = bus.ex_taken ? ex_rel : ex_plus4;
            NPC_JUMP:   actual_npc = ex_rel;
            NPC_JALR:   actual_npc = jalr_tgt;
            default:    actual_npc = ex_plus4;
        endcase
        bus.flush = bus.ex_valid && (actual_npc != bus.ex_pred_npc);
    end

    // IF prediction from pre-update BTB contents
    always_comb begin
        if_hit       = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
        bus.pred_npc = (if_hit && ctr_q[if_idx][1]) ? tgt_q[if_idx] : pc_q + WIDTH'(4);
    end

    assign bus.pc = pc_q;

    // PC register: redirect beats stall
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pc_q <= RESET_PC;
        end else if (bus.flush) begin
            pc_q <= actual_npc;
        end else if (bus.pc_write) begin
            pc_q <= bus.pred_npc;
        end
    end

    // BTB allocate/train on resolved control-flow instructions
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid_q <= '0;
            for (int i = 0; i < int'(BTB_ENTRIES); i++) begin
                tag_q[i] <= '0;
                tgt_q[i] <= '0;
                ctr_q[i] <= 2'b01;
            end
        end else if (upd_en) begin
            if (upd_hit) begin
                if (upd_taken) begin
                    ctr_q[ex_idx] <= (ctr_q[ex_idx] == 2'b11) ? 2'b11 : ctr_q[ex_idx] + 2'b01;
                    tgt_q[ex_idx] <= taken_tgt;
                end else begin
                    ctr_q[ex_idx] <= (ctr_q[ex_idx] == 2'b00) ? 2'b00 : ctr_q[ex_idx] - 2'b01;
                end
            end else begin
                valid_q[ex_idx] <= 1'b1;
                tag_q[ex_idx]   <= ex_tag;
                tgt_q[ex_idx]   <= taken_tgt;
                ctr_q[ex_idx]   <= is_branch ? (bus.ex_taken ? 2'b10 : 2'b01) : 2'b11;
            end
        end
    end

`ifdef NPC_PERF_EN
    // Performance counters: resolved control-flow instructions and flush cycles
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            perf_ctl  <= '0;
            perf_miss <= '0;
        end else begin
            if (upd_en) perf_ctl <= perf_ctl + WIDTH'(1);
            if (bus.flush) perf_miss <= perf_miss + WIDTH'(1);
        end
    end
`endif
endmodule
